dot_matrix_frame_buffer: RTL and testbench

DOT_MATRIX_FRAME_BUFFER -- requirements
Module: dot_matrix_frame_buffer

---
 rtl/dot_matrix_frame_buffer.sv | 121 ++++++++++++
 tb/tb_dot_matrix_frame_buffer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/dot_matrix_frame_buffer.sv
// Double-buffered 8x8 dot-matrix frame store with horizontal scroll.
// Latency: scan_column is registered, one cycle after scan_row is sampled.
// Backpressure: wr_ready drops while a swap is pending, until the next scanner frame end.
module dot_matrix_frame_buffer #(
  parameter int SCROLL_FRAMES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [2:0] wr_row,
  input  logic [7:0] wr_data,
  input  logic       swap_req,
  output logic       swap_pending,
  input  logic       scroll_en,
  input  logic [2:0] scan_row,
  input  logic       scan_frame_end,
  output logic [7:0] scan_column,
  output logic       swap_done
);

  typedef enum logic {FILL = 1'b0, PENDING = 1'b1} state_t;

  state_t     state;
  state_t     state_next;
  logic [7:0] bank0 [8];
  logic [7:0] bank1 [8];
  logic       bank_sel;   // 0: bank0 is front, 1: bank1 is front
  logic [7:0] frame_cnt;
  logic [2:0] offset;
  logic       wr_fire;
  logic       swap_fire;
  logic [7:0] front_row;

  // rotate left: bit n of d lands at bit (n + off) mod 8
  function automatic logic [7:0] rotl8(input logic [7:0] d, input logic [2:0] off);
    logic [7:0] r;
    logic [2:0] idx;
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      idx    = 3'(i) + off;
      r[idx] = d[i];
    end
    return r;
  endfunction

  assign wr_fire   = wr_valid && wr_ready;
  assign swap_fire = (state == PENDING) && scan_frame_end;
  assign front_row = bank_sel ? bank1[scan_row] : bank0[scan_row];

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FILL;
    else        state <= state_next;
  end

  // next-state: a swap request arms, the scanner's frame end publishes
  always_comb begin
    state_next = state;
    case (state)
      FILL:    if (swap_req)       state_next = PENDING;
      PENDING: if (scan_frame_end) state_next = FILL;
      default:                     state_next = FILL;
    endcase
  end

  // outputs decoded from the state register
  always_comb begin
    wr_ready     = (state == FILL);
    swap_pending = (state == PENDING);
  end

  // back-buffer writes; only the bank not selected as front is touched
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) begin
        bank0[i] <= 8'h00;
        bank1[i] <= 8'h00;
      end
    end else if (wr_fire) begin
      if (bank_sel) bank0[wr_row] <= wr_data;
      else          bank1[wr_row] <= wr_data;
    end
  end

  // bank select flips on the swap edge, swap_done echoes it one cycle later
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bank_sel  <= 1'b0;
      swap_done <= 1'b0;
    end else begin
      swap_done <= swap_fire;
      if (swap_fire) bank_sel <= ~bank_sel;
    end
  end

  // scroll counters; a swap restarts the new frame unscrolled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cnt <= 8'd0;
      offset    <= 3'd0;
    end else if (swap_fire) begin
      frame_cnt <= 8'd0;
      offset    <= 3'd0;
    end else if (scroll_en && scan_frame_end) begin
      if (frame_cnt == 8'(SCROLL_FRAMES - 1)) begin
        frame_cnt <= 8'd0;
        offset    <= offset + 3'd1;
      end else begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

  // registered column output from the current (pre-swap) bank and offset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) scan_column <= 8'h00;
    else        scan_column <= rotl8(front_row, offset);
  end

endmodule

// File: tb/tb_dot_matrix_frame_buffer.sv
// Directed bench for dot_matrix_frame_buffer with hand-computed expectations.
// Inputs change 1 time unit after the rising edge, outputs sampled there too.
// Instantiated with SCROLL_FRAMES=2 so the scroll sequence stays short.
module tb_dot_matrix_frame_buffer;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_valid;
  logic       wr_ready;
  logic [2:0] wr_row;
  logic [7:0] wr_data;
  logic       swap_req;
  logic       swap_pending;
  logic       scroll_en;
  logic [2:0] scan_row;
  logic       scan_frame_end;
  logic [7:0] scan_column;
  logic       swap_done;

  int n_checks = 0;
  int n_fails  = 0;

  logic [7:0] pat [8];

  dot_matrix_frame_buffer #(.SCROLL_FRAMES(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_row         (wr_row),
    .wr_data        (wr_data),
    .swap_req       (swap_req),
    .swap_pending   (swap_pending),
    .scroll_en      (scroll_en),
    .scan_row       (scan_row),
    .scan_frame_end (scan_frame_end),
    .scan_column    (scan_column),
    .swap_done      (swap_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %02h, expected %02h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_row(input logic [2:0] row, input logic [7:0] data);
    wr_valid = 1'b1; wr_row = row; wr_data = data;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic frame_pulse();
    scan_frame_end = 1'b1;
    step();
    scan_frame_end = 1'b0;
    step();
  endtask

  task automatic do_swap();
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    scan_frame_end = 1'b1;
    step();
    scan_frame_end = 1'b0;
    step();
  endtask

  initial begin
    pat[0] = 8'h18; pat[1] = 8'h24; pat[2] = 8'h42; pat[3] = 8'hC3;
    pat[4] = 8'h42; pat[5] = 8'h42; pat[6] = 8'h42; pat[7] = 8'h7E;

    reset = 1'b0; wr_valid = 1'b0; wr_row = 3'd0; wr_data = 8'h00;
    swap_req = 1'b0; scroll_en = 1'b0; scan_row = 3'd0; scan_frame_end = 1'b0;
    step(); step();
    check("rst_wr_ready", {7'd0, wr_ready}, 8'h01);
    check("rst_pending",  {7'd0, swap_pending}, 8'h00);
    check("rst_done",     {7'd0, swap_done}, 8'h00);
    check("rst_column",   scan_column, 8'h00);
    reset = 1'b1;

    // fill back buffer; last write shares the edge with swap_req
    for (int i = 0; i < 7; i++) write_row(3'(i), pat[i]);
    wr_valid = 1'b1; wr_row = 3'd7; wr_data = pat[7]; swap_req = 1'b1;
    step();
    wr_valid = 1'b0; swap_req = 1'b0;
    check("pend_after_req", {7'd0, swap_pending}, 8'h01);
    check("ready_in_pend",  {7'd0, wr_ready}, 8'h00);

    // write attempt while pending must be refused
    wr_valid = 1'b1; wr_row = 3'd3; wr_data = 8'hFF;
    step();
    wr_valid = 1'b0;
    check("ready_still_low", {7'd0, wr_ready}, 8'h00);
    check("no_done_yet",     {7'd0, swap_done}, 8'h00);

    scan_frame_end = 1'b1;
    step();
    scan_frame_end = 1'b0;
    check("swap_done_pulse", {7'd0, swap_done}, 8'h01);
    check("pend_cleared",    {7'd0, swap_pending}, 8'h00);
    step();
    check("swap_done_once",  {7'd0, swap_done}, 8'h00);

    for (int i = 0; i < 8; i++) begin
      scan_row = 3'(i);
      step();
      check($sformatf("front_row%0d", i), scan_column, pat[i]);
    end

    // swap_req together with frame end in FILL only arms the swap
    scan_row = 3'd3;
    swap_req = 1'b1; scan_frame_end = 1'b1;
    step();
    swap_req = 1'b0; scan_frame_end = 1'b0;
    check("coinc_pending", {7'd0, swap_pending}, 8'h01);
    step();
    check("coinc_no_done", {7'd0, swap_done}, 8'h00);
    check("coinc_old_front", scan_column, 8'hC3);
    scan_frame_end = 1'b1;
    step();
    scan_frame_end = 1'b0;
    check("coinc_done", {7'd0, swap_done}, 8'h01);
    step();
    // new front is the initial all-zero bank: refused FF write never landed
    check("row3_unchanged", scan_column, 8'h00);

    // scroll: back now holds the pattern bank, put 01 in row 0 and publish
    write_row(3'd0, 8'h01);
    do_swap();
    scan_row = 3'd0; scroll_en = 1'b1;
    step();
    check("scroll_0", scan_column, 8'h01);
    frame_pulse();
    check("scroll_1", scan_column, 8'h01);
    frame_pulse();
    check("scroll_2", scan_column, 8'h02);
    for (int k = 3; k <= 14; k++) frame_pulse();
    check("scroll_14", scan_column, 8'h80);
    frame_pulse(); frame_pulse();
    check("scroll_16", scan_column, 8'h01);

    // reach offset 1 with the frame counter mid-step, then swap on the step edge
    frame_pulse(); frame_pulse(); frame_pulse();
    check("scroll_pre", scan_column, 8'h02);
    write_row(3'd0, 8'h03);
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    scan_frame_end = 1'b1;
    step();
    scan_frame_end = 1'b0;
    check("swap_edge_old", scan_column, 8'h02);
    check("swap_edge_done", {7'd0, swap_done}, 8'h01);
    step();
    check("swap_unrotated", scan_column, 8'h03);

    // reset during PENDING abandons the swap
    scroll_en = 1'b0;
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    check("pend_before_rst", {7'd0, swap_pending}, 8'h01);
    reset = 1'b0;
    #1;
    check("rst_pend_clear", {7'd0, swap_pending}, 8'h00);
    check("rst_ready_set",  {7'd0, wr_ready}, 8'h01);
    check("rst_col_zero",   scan_column, 8'h00);
    step();
    reset = 1'b1;
    // first edge after release takes a write
    write_row(3'd0, 8'hAA);
    check("post_rst_no_done", {7'd0, swap_done}, 8'h00);
    frame_pulse();
    check("frame_no_done", {7'd0, swap_done}, 8'h00);
    check("frame_no_pend", {7'd0, swap_pending}, 8'h00);
    do_swap();
    scan_row = 3'd0;
    step();
    check("post_rst_write", scan_column, 8'hAA);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
